// File: rtl/rob_alloc_ctrl.sv
// ----------------------------------------------------------------------------
// rob_alloc_ctrl
//   Reorder-buffer allocation and sequencing controller. Hands out ROB entry
//   pointers to two dispatch slots per cycle, tracks free entries from the
//   commit count, generates the all-or-nothing dispatch stall and runs a
//   RUN/RECOVER state machine on branch-mispredict flush.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   i_req_1/i_req_2     dispatch slot requests (slot 2 only with slot 1)
//   i_com_num           entries retired this cycle (0..2)
//   i_flush             mispredict flush, drops all uncommitted entries
//   o_dp_vld_1/2        slot allocated this cycle
//   o_dp_ptr_1/2        slot entry pointer (ptr_2 = ptr_1 + 1, wraps)
//   o_stall             dispatch stall, both slots together
//   o_free_cnt          free entries, 0..ENT_NUM
//   o_empty / o_full    free_cnt == ENT_NUM / free_cnt == 0
//   o_recovering        FSM in RECOVER
//
// Optional build macro ROB_ALLOC_PERF_EN adds:
//   o_stall_cyc         saturating count of stalled cycles with a request
//   o_occ_hwm           occupancy high-water mark since reset
// ----------------------------------------------------------------------------

// Per-slot pointer / valid generation. Slot N sits N entries past the base.
module rob_alloc_slot #(
  parameter int ENT_SEL = 6,
  parameter int SLOT    = 0
) (
  input  logic [ENT_SEL-1:0] base_ptr_i,
  input  logic               req_i,
  input  logic               stall_i,
  output logic               vld_o,
  output logic [ENT_SEL-1:0] ptr_o
);
  assign vld_o = req_i & ~stall_i;
  assign ptr_o = base_ptr_i + ENT_SEL'(SLOT);
endmodule

module rob_alloc_ctrl #(
  parameter int ENT_NUM     = 64,
  parameter int ENT_SEL     = 6,
  parameter int RECOVER_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req_1,
  input  logic               i_req_2,
  input  logic [1:0]         i_com_num,
  input  logic               i_flush,
  output logic               o_dp_vld_1,
  output logic [ENT_SEL-1:0] o_dp_ptr_1,
  output logic               o_dp_vld_2,
  output logic [ENT_SEL-1:0] o_dp_ptr_2,
  output logic               o_stall,
  output logic [ENT_SEL:0]   o_free_cnt,
  output logic               o_empty,
  output logic               o_full,
  output logic               o_recovering
`ifdef ROB_ALLOC_PERF_EN
  ,
  output logic [31:0]        o_stall_cyc,
  output logic [ENT_SEL:0]   o_occ_hwm
`endif
);

  localparam int NUM_SLOTS = 2;
  localparam int RC_W      = 4;
  localparam logic [ENT_SEL:0] FULL_CNT = ENT_NUM[ENT_SEL:0];

  typedef enum logic {RUN = 1'b0, RECOVER = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [RC_W-1:0]    rcv_cnt_q, rcv_cnt_d;
  logic [ENT_SEL-1:0] dp_ptr_q, dp_ptr_d;
  logic [ENT_SEL-1:0] com_ptr_q, com_ptr_d;
  logic [ENT_SEL:0]   free_cnt_q, free_cnt_d;

  logic [NUM_SLOTS-1:0]              req;
  logic [NUM_SLOTS-1:0]              vld;
  logic [NUM_SLOTS-1:0][ENT_SEL-1:0] ptr;
  logic [1:0]                        need;
  logic [1:0]                        alloc;
  logic                              stall;

  assign req  = {i_req_2, i_req_1};
  assign need = {1'b0, req[0]} + {1'b0, req[1]};

  // Stall only looks at the registered free count: entries committed this
  // cycle become usable next cycle, which keeps commit off the stall path.
  assign stall = i_flush | (state_q != RUN)
               | (free_cnt_q < {{(ENT_SEL-1){1'b0}}, need});

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    rob_alloc_slot #(.ENT_SEL(ENT_SEL), .SLOT(s)) u_slot (
      .base_ptr_i (dp_ptr_q),
      .req_i      (req[s]),
      .stall_i    (stall),
      .vld_o      (vld[s]),
      .ptr_o      (ptr[s])
    );
  end

  assign alloc = {1'b0, vld[0]} + {1'b0, vld[1]};

  always_comb begin
    state_d    = state_q;
    rcv_cnt_d  = rcv_cnt_q;
    dp_ptr_d   = dp_ptr_q;
    free_cnt_d = free_cnt_q;
    // Commits are honoured in every state, including the flush cycle.
    com_ptr_d  = com_ptr_q + {{(ENT_SEL-2){1'b0}}, i_com_num};

    case (state_q)
      RUN: begin
        if (i_flush) begin
          dp_ptr_d   = com_ptr_d;
          free_cnt_d = FULL_CNT;
          rcv_cnt_d  = RC_W'(RECOVER_CYC - 1);
          state_d    = RECOVER;
        end else begin
          dp_ptr_d   = dp_ptr_q + {{(ENT_SEL-2){1'b0}}, alloc};
          free_cnt_d = free_cnt_q + {{(ENT_SEL-1){1'b0}}, i_com_num}
                                  - {{(ENT_SEL-1){1'b0}}, alloc};
        end
      end
      RECOVER: begin
        // ROB is logically empty here; free_cnt stays pinned at ENT_NUM.
        if (i_flush) begin
          dp_ptr_d  = com_ptr_d;
          rcv_cnt_d = RC_W'(RECOVER_CYC - 1);
        end else if (rcv_cnt_q == '0) begin
          state_d = RUN;
        end else begin
          rcv_cnt_d = rcv_cnt_q - 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      rcv_cnt_q  <= '0;
      dp_ptr_q   <= '0;
      com_ptr_q  <= '0;
      free_cnt_q <= FULL_CNT;
    end else begin
      state_q    <= state_d;
      rcv_cnt_q  <= rcv_cnt_d;
      dp_ptr_q   <= dp_ptr_d;
      com_ptr_q  <= com_ptr_d;
      free_cnt_q <= free_cnt_d;
    end
  end

  assign o_dp_vld_1   = vld[0];
  assign o_dp_vld_2   = vld[1];
  assign o_dp_ptr_1   = ptr[0];
  assign o_dp_ptr_2   = ptr[1];
  assign o_stall      = stall;
  assign o_free_cnt   = free_cnt_q;
  assign o_empty      = (free_cnt_q == FULL_CNT);
  assign o_full       = (free_cnt_q == '0);
  assign o_recovering = (state_q == RECOVER);

`ifdef ROB_ALLOC_PERF_EN
  logic [31:0]      stall_cyc_q, stall_cyc_d;
  logic [ENT_SEL:0] occ_hwm_q, occ_hwm_d;
  logic [ENT_SEL:0] occ;

  assign occ = FULL_CNT - free_cnt_q;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    occ_hwm_d   = occ_hwm_q;
    if (stall && (need != 2'd0) && (stall_cyc_q != '1))
      stall_cyc_d = stall_cyc_q + 32'd1;
    if (occ > occ_hwm_q)
      occ_hwm_d = occ;
  end

  // Flush deliberately leaves these alone; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      occ_hwm_q   <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      occ_hwm_q   <= occ_hwm_d;
    end
  end

  assign o_stall_cyc = stall_cyc_q;
  assign o_occ_hwm   = occ_hwm_q;
`endif

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rob_alloc_ctrl
//   Table-driven start-up vectors, hand-written corner sequences (exact-full,
//   commit/alloc same cycle, pointer wrap, flush/recover, reset mid-recover)
//   and a randomized phase. Expectations come from a counter/pointer model
//   of the ROB built from the allocation rules with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_rob_alloc_ctrl;

  localparam int ENT_NUM     = 64;
  localparam int ENT_SEL     = 6;
  localparam int RECOVER_CYC = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req1 = 1'b0, req2 = 1'b0, flush = 1'b0;
  logic [1:0]         com = 2'd0;
  logic               vld1, vld2, stall, empty, full, recovering;
  logic [ENT_SEL-1:0] ptr1, ptr2;
  logic [ENT_SEL:0]   free_cnt;
`ifdef ROB_ALLOC_PERF_EN
  logic [31:0]        stall_cyc;
  logic [ENT_SEL:0]   occ_hwm;
`endif

  rob_alloc_ctrl #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL), .RECOVER_CYC(RECOVER_CYC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_1      (req1),
    .i_req_2      (req2),
    .i_com_num    (com),
    .i_flush      (flush),
    .o_dp_vld_1   (vld1),
    .o_dp_ptr_1   (ptr1),
    .o_dp_vld_2   (vld2),
    .o_dp_ptr_2   (ptr2),
    .o_stall      (stall),
    .o_free_cnt   (free_cnt),
    .o_empty      (empty),
    .o_full       (full),
    .o_recovering (recovering)
`ifdef ROB_ALLOC_PERF_EN
    ,
    .o_stall_cyc  (stall_cyc),
    .o_occ_hwm    (occ_hwm)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;

  // Reference model: pointers and counts as plain integers.
  int m_dp, m_com, m_free, m_left;   // m_left = forced-stall cycles remaining
  int m_stall_cyc, m_hwm;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_stall_now();
    int need = int'(req1) + int'(req2);
    return flush || (m_left > 0) || (m_free < need);
  endfunction

  task automatic model_reset();
    m_dp = 0; m_com = 0; m_free = ENT_NUM; m_left = 0;
    m_stall_cyc = 0; m_hwm = 0;
  endtask

  task automatic check_model();
    bit st = m_stall_now();
    chk("stall", int'(stall), int'(st));
    chk("vld1", int'(vld1), int'(req1 && !st));
    chk("vld2", int'(vld2), int'(req2 && !st));
    chk("ptr1", int'(ptr1), m_dp);
    chk("ptr2", int'(ptr2), (m_dp + 1) % ENT_NUM);
    chk("free_cnt", int'(free_cnt), m_free);
    chk("empty", int'(empty), int'(m_free == ENT_NUM));
    chk("full", int'(full), int'(m_free == 0));
    chk("recovering", int'(recovering), int'(m_left > 0));
`ifdef ROB_ALLOC_PERF_EN
    chk("stall_cyc", int'(stall_cyc), m_stall_cyc);
    chk("occ_hwm", int'(occ_hwm), m_hwm);
`endif
  endtask

  // Drive one cycle's inputs at the falling edge, then check before the rise.
  task automatic drive(input bit r1, input bit r2, input int c, input bit f);
    @(negedge clk);
    req1 = r1; req2 = r2; com = 2'(c); flush = f;
    #1;
    if ((r2 && !r1) || c > 2 || c > (ENT_NUM - m_free)) begin
      errs++;
      $display("FAIL stim_legal: r1=%0d r2=%0d com=%0d occ=%0d", r1, r2, c, ENT_NUM - m_free);
    end
    check_model();
  endtask

  // Advance through the rising edge and update the model.
  task automatic tick();
    int need, alloc, c;
    bit st;
    need = int'(req1) + int'(req2);
    c    = int'(com);
    st   = m_stall_now();
    alloc = st ? 0 : need;
    @(posedge clk);
    if (st && need > 0) m_stall_cyc++;
    if (ENT_NUM - m_free > m_hwm) m_hwm = ENT_NUM - m_free;
    m_com = (m_com + c) % ENT_NUM;
    if (flush) begin
      m_dp = m_com; m_free = ENT_NUM; m_left = RECOVER_CYC;
    end else if (m_left > 0) begin
      m_left--;
    end else begin
      m_dp   = (m_dp + alloc) % ENT_NUM;
      m_free = m_free + c - alloc;
    end
  endtask

  task automatic step(input bit r1, input bit r2, input int c, input bit f);
    drive(r1, r2, c, f);
    tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    req1 = 0; req2 = 0; com = 0; flush = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_recovering", int'(recovering), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_vld", int'({vld1, vld2}), 0);
    chk("rst_free", int'(free_cnt), ENT_NUM);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit r1, r2; int c; bit f;
    bit v1, v2; int p1, p2; bit st; int fr;
  } vec_t;

  vec_t tbl[4];

  initial begin
    // Start-up burst: three dual allocations then idle.
    tbl[0] = '{1, 1, 0, 0, 1, 1, 0, 1, 0, 64};
    tbl[1] = '{1, 1, 0, 0, 1, 1, 2, 3, 0, 62};
    tbl[2] = '{1, 1, 0, 0, 1, 1, 4, 5, 0, 60};
    tbl[3] = '{0, 0, 0, 0, 0, 0, 6, 7, 0, 58};

    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].r1, tbl[i].r2, tbl[i].c, tbl[i].f);
      chk("tbl_vld1", int'(vld1), int'(tbl[i].v1));
      chk("tbl_vld2", int'(vld2), int'(tbl[i].v2));
      chk("tbl_ptr1", int'(ptr1), tbl[i].p1);
      chk("tbl_ptr2", int'(ptr2), tbl[i].p2);
      chk("tbl_stall", int'(stall), int'(tbl[i].st));
      chk("tbl_free", int'(free_cnt), tbl[i].fr);
      tick();
    end

    // Fill to exactly one free entry, then dual request must stall.
    for (int i = 0; i < 28; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    chk("exact_full_stall", int'(stall), 1);
    chk("exact_full_vld", int'({vld1, vld2}), 0);
    tick();
    drive(1, 0, 0, 0);
    chk("last_vld1", int'(vld1), 1);
    chk("last_ptr1", int'(ptr1), 63);
    tick();
    drive(0, 0, 0, 0);
    chk("now_full", int'(full), 1);
    tick();

    // Full ROB: commit and dual request together -> stall, allocate next.
    drive(1, 1, 2, 0);
    chk("com_alloc_stall", int'(stall), 1);
    tick();
    drive(1, 1, 0, 0);
    chk("com_alloc_vld", int'({vld1, vld2}), 3);
    chk("com_alloc_ptr", int'(ptr1), 0);
    tick();
    drive(0, 0, 0, 0);
    chk("refull_free", int'(free_cnt), 0);
    tick();

    // Flush with com_ptr=10, dp_ptr=20 and one same-cycle commit.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, 2, 0);
    drive(0, 0, 1, 1);
    chk("flush_stall", int'(stall), 1);
    tick();
    for (int i = 0; i < RECOVER_CYC; i++) begin
      drive(1, 0, 0, 0);
      chk("rcv_stall", int'(stall), 1);
      chk("rcv_flag", int'(recovering), 1);
      chk("rcv_ptr", int'(ptr1), 11);
      chk("rcv_free", int'(free_cnt), 64);
      tick();
    end
    drive(1, 0, 0, 0);
    chk("resume_vld", int'(vld1), 1);
    chk("resume_ptr", int'(ptr1), 11);
    tick();

    // Reset landing mid-RECOVER with dp_ptr=30.
    do_reset();
    for (int i = 0; i < 15; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 2, 0);
    step(0, 0, 0, 1);
    drive(0, 0, 0, 0);
    chk("pre_rst_rcv", int'(recovering), 1);
    chk("pre_rst_ptr", int'(ptr1), 30);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_rcv", int'(recovering), 0);
    chk("mid_rst_stall", int'(stall), 0);
    chk("mid_rst_free", int'(free_cnt), 64);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 0, 0);
    chk("post_rst_ptr", int'(ptr1), 0);
    chk("post_rst_vld", int'(vld1), 1);
    tick();

    // Pointer wrap: dp_ptr=63 with a dual request.
    do_reset();
    for (int i = 0; i < 31; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 2, 0);
    drive(1, 1, 0, 0);
    chk("wrap_ptr1", int'(ptr1), 63);
    chk("wrap_ptr2", int'(ptr2), 0);
    chk("wrap_vld", int'({vld1, vld2}), 3);
    tick();
    drive(0, 0, 0, 0);
    chk("wrap_next", int'(ptr1), 1);
    tick();

    // Randomized legal traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r1, r2, f;
      int c, occ, cmax;
      r1   = ($urandom_range(0, 3) != 0);
      r2   = r1 && ($urandom_range(0, 1) != 0);
      f    = ($urandom_range(0, 39) == 0);
      occ  = ENT_NUM - m_free;
      cmax = (occ < 2) ? occ : 2;
      c    = $urandom_range(0, cmax);
      if ($urandom_range(0, 2) == 0) c = 0;
      step(r1, r2, c, f);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
